if_id_queue: RTL

- Decoupling instruction queue between the instruction fetch stage and the instruction decode stage of the Titan RV32 pipeline.
- Captures each fetched {pc, instruction, fault} triple and presents it in order to decode via valid/ready.
- Absorbs fetch responses that arrive while decode is stalled.
- Discards all queued fetches on a control-flow flush (branch/jump/trap redirect).

---
 rtl/if_id_queue.sv | 95 +++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue for the Titan RV32 pipeline.
// Holds {pc, instruction, fault} entries in order; flush drops them all.
module if_id_queue #(
    parameter int               XLEN  = 32,
    parameter int               DEPTH = 2,
    parameter logic [XLEN-1:0]  NOP   = XLEN'(32'h00000013)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [XLEN-1:0]            if_pc,
    input  logic [XLEN-1:0]            if_instruction,
    input  logic                       if_fault,
    input  logic                       if_valid,
    output logic                       if_ready,
    output logic [XLEN-1:0]            id_pc,
    output logic [XLEN-1:0]            id_instruction,
    output logic                       id_fault,
    output logic                       id_valid,
    input  logic                       id_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [XLEN-1:0] r_inst  [DEPTH];
    logic            r_fault [DEPTH];
    logic [AW-1:0]   r_rptr;
    logic [AW-1:0]   r_wptr;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_last_pc;

    logic w_push;
    logic w_pop;
    logic w_nempty;

    assign w_nempty = (r_count != '0);
    assign if_ready = (r_count < CW'(DEPTH));
    assign id_valid = w_nempty;
    assign count    = r_count;
    assign w_push   = if_valid & if_ready;
    assign w_pop    = w_nempty & id_ready;

    // Empty queue shows a NOP but keeps the last pc it presented.
    assign id_pc          = w_nempty ? r_pc[r_rptr]    : r_last_pc;
    assign id_instruction = w_nempty ? r_inst[r_rptr]  : NOP;
    assign id_fault       = w_nempty ? r_fault[r_rptr] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr    <= '0;
            r_wptr    <= '0;
            r_count   <= '0;
            r_last_pc <= '0;
        end else begin
            if (w_nempty) begin
                r_last_pc <= r_pc[r_rptr];
            end
            if (flush) begin
                r_rptr  <= '0;
                r_wptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_inst[i]  <= NOP;
                r_fault[i] <= 1'b0;
            end
        end else if (w_push && !flush) begin
            r_pc[r_wptr]    <= if_pc;
            r_inst[r_wptr]  <= if_instruction;
            r_fault[r_wptr] <= if_fault;
        end
    end

endmodule
